// File: rtl/pll_cfg_pkg.sv
// pll_cfg_pkg: shared types and constants for the PLL reconfiguration sequencer.
package pll_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MODE,
    ST_WRITE,
    ST_START,
    ST_WAIT_LOCK,
    ST_ERR
  } state_t;

  localparam logic [5:0] ADDR_MODE  = 6'h00;
  localparam logic [5:0] ADDR_START = 6'h02;

  // One table entry is {addr[5:0], data[31:0]}
  localparam int ENTRY_W = 38;
  localparam int MAX_WR  = 8;
  localparam int TBL_W   = MAX_WR * ENTRY_W;
  localparam int SEL_W   = $clog2(TBL_W);

  // Pull entry i out of a preset table that has been widened to MAX_WR entries
  function automatic logic [ENTRY_W-1:0] get_entry(input logic [TBL_W-1:0] tbl,
                                                   input int unsigned i);
    logic [SEL_W-1:0] base;
    base = SEL_W'(i * ENTRY_W);
    return tbl[base +: ENTRY_W];
  endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// pll_lock_sync: brings the asynchronous PLL locked flag into the mgmt clock
// domain and reports when it has been continuously high long enough.
module pll_lock_sync
  import pll_cfg_pkg::*;
#(
  parameter int LOCK_STABLE = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic pll_locked,
  input  logic clr,
  output logic lk_s,
  output logic lock_ok
);

  localparam int CNT_W = $clog2(LOCK_STABLE + 1);

  logic             meta;
  logic [CNT_W-1:0] stable;

  // Two-flop synchroniser for the locked flag
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      lk_s <= 1'b0;
    end else begin
      meta <= pll_locked;
      lk_s <= meta;
    end
  end

  // Count consecutive locked cycles; any dropout or a clear restarts the count
  always_ff @(posedge clk) begin
    if (rst || clr || !lk_s) begin
      stable <= '0;
    end else if (!lock_ok) begin
      stable <= stable + CNT_W'(1);
    end
  end

  assign lock_ok = lk_s && (stable == CNT_W'(LOCK_STABLE - 1));

endmodule

// File: rtl/pll_cfg_seq.sv
// pll_cfg_seq: writes a frequency preset into the PLL reconfiguration port,
// triggers the reload, then holds the core in reset until lock is stable.
module pll_cfg_seq
  import pll_cfg_pkg::*;
#(
  parameter int                          NUM_WR       = 3,
  parameter logic [NUM_WR*ENTRY_W-1:0]   PRESET0      = '0,
  parameter logic [NUM_WR*ENTRY_W-1:0]   PRESET1      = '0,
  parameter int                          LOCK_STABLE  = 16,
  parameter int                          LOCK_TIMEOUT = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_req,
  input  logic        cfg_sel,
  input  logic        pll_locked,
  output logic [5:0]  mgmt_address,
  output logic        mgmt_write,
  output logic [31:0] mgmt_writedata,
  input  logic        mgmt_waitrequest,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        core_reset
);

  localparam int IDX_W = $clog2(NUM_WR) + 1;
  localparam int TMO_W = $clog2(LOCK_TIMEOUT + 1);

  localparam logic [TBL_W-1:0] TBL0     = TBL_W'(PRESET0);
  localparam logic [TBL_W-1:0] TBL1     = TBL_W'(PRESET1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WR - 1);
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(LOCK_TIMEOUT);

  state_t             state;
  logic               sel;
  logic [IDX_W-1:0]   idx;
  logic [TMO_W-1:0]   tmo;
  logic               pend;
  logic               pend_sel;
  logic               lk_s;
  logic               lock_ok;
  logic               go_mode;
  logic               go_sel;
  logic [ENTRY_W-1:0] cur_entry;

  pll_lock_sync #(
    .LOCK_STABLE(LOCK_STABLE)
  ) u_lock_sync (
    .clk        (clk),
    .rst        (rst),
    .pll_locked (pll_locked),
    .clr        (state != ST_WAIT_LOCK),
    .lk_s       (lk_s),
    .lock_ok    (lock_ok)
  );

  assign cur_entry = get_entry(sel ? TBL1 : TBL0, 32'(idx));

  // Decide whether a new sequence starts this cycle, and with which preset;
  // on relock a queued or same-cycle request replaces the return to idle
  always_comb begin
    go_mode = 1'b0;
    go_sel  = cfg_sel;
    case (state)
      ST_IDLE, ST_ERR: go_mode = cfg_req;
      ST_WAIT_LOCK: begin
        if (lock_ok) begin
          go_mode = pend | cfg_req;
          go_sel  = cfg_req ? cfg_sel : pend_sel;
        end
      end
      default: ;
    endcase
  end

  // Sequencer FSM with registered Avalon and status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_WAIT_LOCK;
      mgmt_write     <= 1'b0;
      mgmt_address   <= '0;
      mgmt_writedata <= '0;
      busy           <= 1'b1;
      done           <= 1'b0;
      error          <= 1'b0;
      core_reset     <= 1'b1;
      pend           <= 1'b0;
      pend_sel       <= 1'b0;
      sel            <= 1'b0;
      idx            <= '0;
      tmo            <= '0;
    end else begin
      done <= 1'b0;
      if (cfg_req && busy) begin
        pend     <= 1'b1;
        pend_sel <= cfg_sel;
      end
      case (state)
        ST_IDLE: begin
          if (!lk_s) begin
            state      <= ST_WAIT_LOCK;
            busy       <= 1'b1;
            core_reset <= 1'b1;
            tmo        <= '0;
          end
        end
        ST_MODE: begin
          if (mgmt_write && !mgmt_waitrequest) begin
            mgmt_write <= 1'b0;
            state      <= ST_WRITE;
            idx        <= '0;
          end
        end
        ST_WRITE: begin
          if (!mgmt_write) begin
            mgmt_write     <= 1'b1;
            mgmt_address   <= cur_entry[ENTRY_W-1:32];
            mgmt_writedata <= cur_entry[31:0];
          end else if (!mgmt_waitrequest) begin
            mgmt_write <= 1'b0;
            if (idx == LAST_IDX) begin
              state <= ST_START;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        ST_START: begin
          if (!mgmt_write) begin
            mgmt_write     <= 1'b1;
            mgmt_address   <= ADDR_START;
            mgmt_writedata <= '0;
          end else if (!mgmt_waitrequest) begin
            mgmt_write <= 1'b0;
            state      <= ST_WAIT_LOCK;
            tmo        <= '0;
          end
        end
        ST_WAIT_LOCK: begin
          if (lock_ok) begin
            done       <= 1'b1;
            state      <= ST_IDLE;
            busy       <= 1'b0;
            core_reset <= 1'b0;
          end else if (tmo == TMO_MAX) begin
            state <= ST_ERR;
            error <= 1'b1;
            busy  <= 1'b0;
          end else begin
            tmo <= tmo + TMO_W'(1);
          end
        end
        ST_ERR: ;
        default: state <= ST_WAIT_LOCK;
      endcase
      if (go_mode) begin
        state          <= ST_MODE;
        sel            <= go_sel;
        idx            <= '0;
        mgmt_write     <= 1'b1;
        mgmt_address   <= ADDR_MODE;
        mgmt_writedata <= '0;
        busy           <= 1'b1;
        core_reset     <= 1'b1;
        error          <= 1'b0;
        pend           <= 1'b0;
      end
    end
  end

endmodule
